// File: rtl/jt5205_adpcm_mc.sv
`default_nettype none
// ============================================================================
// Module   : jt5205_adpcm_mc
// Purpose  : CH-channel time-multiplexed OKI/MSM5205 ADPCM decoder with one
//            shared step table and shift-add datapath. Optional per-channel
//            restart input under JT5205_MC_CHRST_EN.
// Revision : 1.0
// ============================================================================
module jt5205_adpcm_mc #(
    parameter int CH = 4,
    parameter int OW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [4*CH-1:0]   din,
    input  logic [CH-1:0]     bits3,
`ifdef JT5205_MC_CHRST_EN
    input  logic [CH-1:0]     chrst,
`endif
    output logic [OW*CH-1:0]  sound,
    output logic              done,
    output logic              busy,
    output logic              ovr
);

    localparam int              CHW     = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CHW-1:0]  LAST_CH = CHW'(CH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ACC0 = 3'd2,
        ACC1 = 3'd3,
        ACC2 = 3'd4,
        UPD  = 3'd5
    } state_t;

    function automatic logic [10:0] step_lut(input logic [5:0] i);
        logic [10:0] r;
        case (i)
            6'd0:  r = 11'd16;   6'd1:  r = 11'd17;   6'd2:  r = 11'd19;   6'd3:  r = 11'd21;
            6'd4:  r = 11'd23;   6'd5:  r = 11'd25;   6'd6:  r = 11'd28;   6'd7:  r = 11'd31;
            6'd8:  r = 11'd34;   6'd9:  r = 11'd37;   6'd10: r = 11'd41;   6'd11: r = 11'd45;
            6'd12: r = 11'd50;   6'd13: r = 11'd55;   6'd14: r = 11'd60;   6'd15: r = 11'd66;
            6'd16: r = 11'd73;   6'd17: r = 11'd80;   6'd18: r = 11'd88;   6'd19: r = 11'd97;
            6'd20: r = 11'd107;  6'd21: r = 11'd118;  6'd22: r = 11'd130;  6'd23: r = 11'd143;
            6'd24: r = 11'd157;  6'd25: r = 11'd173;  6'd26: r = 11'd190;  6'd27: r = 11'd209;
            6'd28: r = 11'd230;  6'd29: r = 11'd253;  6'd30: r = 11'd279;  6'd31: r = 11'd307;
            6'd32: r = 11'd337;  6'd33: r = 11'd371;  6'd34: r = 11'd408;  6'd35: r = 11'd449;
            6'd36: r = 11'd494;  6'd37: r = 11'd544;  6'd38: r = 11'd598;  6'd39: r = 11'd658;
            6'd40: r = 11'd724;  6'd41: r = 11'd796;  6'd42: r = 11'd876;  6'd43: r = 11'd963;
            6'd44: r = 11'd1060; 6'd45: r = 11'd1166; 6'd46: r = 11'd1282; 6'd47: r = 11'd1411;
            default: r = 11'd1552;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [4*CH-1:0] din_q, din_d;
    logic [CH-1:0]   bits3_q, bits3_d;
    logic [5:0]      idx_q [CH];
    logic [5:0]      idx_d [CH];
    logic [11:0]     acc_q [CH];
    logic [11:0]     acc_d [CH];
    logic [11:0]     q_q, q_d;
    logic [10:0]     dn_q, dn_d;
    logic [5:0]      wi_q, wi_d;
    logic [11:0]     wa_q, wa_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;

    logic [3:0]      nib;
    logic            chrst_hit;
    logic            accept;
    logic [10:0]     d;
    logic [13:0]     wa_ext, q_ext, sum;
    logic [11:0]     acc_nx;
    logic [6:0]      idx_sum;
    logic [5:0]      idx_nx;

`ifdef JT5205_MC_CHRST_EN
    assign chrst_hit = chrst[ch_q];
`else
    assign chrst_hit = 1'b0;
`endif

    // 3-bit mode drops the sign bit and pads the LSB
    always_comb begin
        nib = din_q[{ch_q, 2'b00} +: 4];
        if (bits3_q[ch_q]) nib = {din_q[{ch_q, 2'b00} +: 3], 1'b0};
    end

    // Two guard bits: acc + q can reach 2047 + 2910 before saturation
    always_comb begin
        wa_ext = {{2{wa_q[11]}}, wa_q};
        q_ext  = {2'b00, q_q};
        sum    = nib[3] ? (wa_ext - q_ext) : (wa_ext + q_ext);
        if (!sum[13] && (sum[12:11] != 2'b00))     acc_nx = 12'h7FF;
        else if (sum[13] && (sum[12:11] != 2'b11)) acc_nx = 12'h800;
        else                                       acc_nx = sum[11:0];

        idx_sum = {1'b0, wi_q} + {4'b0000, nib[1:0], 1'b0} + 7'd2;
        if (nib[2])          idx_nx = (idx_sum > 7'd48) ? 6'd48 : idx_sum[5:0];
        else if (wi_q == '0) idx_nx = 6'd0;
        else                 idx_nx = wi_q - 6'd1;
    end

    assign accept = cen && ((state_q == IDLE) || ((state_q == UPD) && (ch_q == LAST_CH)));

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        din_d   = din_q;
        bits3_d = bits3_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        q_d     = q_q;
        dn_d    = dn_q;
        wi_d    = wi_q;
        wa_d    = wa_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        d       = '0;

        case (state_q)
            IDLE: ;
            LOAD: begin
                wi_d    = chrst_hit ? 6'd0  : idx_q[ch_q];
                wa_d    = chrst_hit ? 12'd0 : acc_q[ch_q];
                d       = step_lut(wi_d);
                q_d     = {4'b0000, d[10:3]};
                dn_d    = d;
                state_d = ACC0;
            end
            ACC0: begin
                if (nib[2]) q_d = q_q + {1'b0, dn_q};
                dn_d    = dn_q >> 1;
                state_d = ACC1;
            end
            ACC1: begin
                if (nib[1]) q_d = q_q + {1'b0, dn_q};
                dn_d    = dn_q >> 1;
                state_d = ACC2;
            end
            ACC2: begin
                if (nib[0]) q_d = q_q + {1'b0, dn_q};
                state_d = UPD;
            end
            UPD: begin
                idx_d[ch_q] = idx_nx;
                acc_d[ch_q] = acc_nx;
                if (ch_q == LAST_CH) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = LOAD;
            ch_d    = '0;
            din_d   = din;
            bits3_d = bits3;
        end else if (cen) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            din_q   <= '0;
            bits3_q <= '0;
            q_q     <= '0;
            dn_q    <= '0;
            wi_q    <= '0;
            wa_q    <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                idx_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            din_q   <= din_d;
            bits3_q <= bits3_d;
            q_q     <= q_d;
            dn_q    <= dn_d;
            wi_q    <= wi_d;
            wa_q    <= wa_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_sound
        assign sound[OW*c +: OW] = OW'($signed(acc_q[c])) << (OW - 12);
    end

    assign done = done_q;
    assign busy = (state_q != IDLE);
    assign ovr  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_jt5205_adpcm_mc.sv
`default_nettype none
// Bench for jt5205_adpcm_mc: vector table plus directed corner sequences,
// frame results scored against a behavioural model through a queue.
module tb_jt5205_adpcm_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  bits3 = '0;
`ifdef JT5205_MC_CHRST_EN
    logic [3:0]  chrst = '0;
`endif
    logic [47:0] sound;
    logic [63:0] sound16;
    logic        done, busy, ovr;
    logic        done16, busy16, ovr16;

    jt5205_adpcm_mc #(.CH(4), .OW(12)) dut (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .bits3(bits3),
`ifdef JT5205_MC_CHRST_EN
        .chrst(chrst),
`endif
        .sound(sound), .done(done), .busy(busy), .ovr(ovr)
    );

    jt5205_adpcm_mc #(.CH(4), .OW(16)) dut16 (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .bits3(bits3),
`ifdef JT5205_MC_CHRST_EN
        .chrst(chrst),
`endif
        .sound(sound16), .done(done16), .busy(busy16), .ovr(ovr16)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int t;
    logic [47:0] exp_q[$];

    int step_tab [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                          73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
                          279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876,
                          963, 1060, 1166, 1282, 1411, 1552};
    int m_idx [4];
    int m_acc [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_idx[c] = 0;
            m_acc[c] = 0;
        end
    endfunction

    function automatic logic [47:0] model_frame(input logic [15:0] dv, input logic [3:0] b3,
                                                input logic [3:0] cr);
        logic [47:0] r;
        logic [3:0]  n;
        int dd, q, a, ix;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            if (cr[c]) begin
                m_idx[c] = 0;
                m_acc[c] = 0;
            end
            n = dv[4*c +: 4];
            if (b3[c]) n = {n[2:0], 1'b0};
            dd = step_tab[m_idx[c]];
            q  = dd / 8 + (n[2] ? dd : 0) + (n[1] ? dd / 2 : 0) + (n[0] ? dd / 4 : 0);
            a  = n[3] ? m_acc[c] - q : m_acc[c] + q;
            if (a > 2047)  a = 2047;
            if (a < -2048) a = -2048;
            ix = n[2] ? m_idx[c] + 2 * (int'(n[1:0]) + 1) : m_idx[c] - 1;
            if (ix < 0)  ix = 0;
            if (ix > 48) ix = 48;
            m_acc[c] = a;
            m_idx[c] = ix;
            r[12*c +: 12] = a[11:0];
        end
        return r;
    endfunction

    // Scoreboard: every done pulse retires one expected frame
    always @(negedge clk) begin
        logic [47:0] e;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending frame");
            end else begin
                e = exp_q.pop_front();
                for (int c = 0; c < 4; c++) begin
                    check($sformatf("sb_slice%0d", c), {20'd0, sound[12*c +: 12]}, {20'd0, e[12*c +: 12]});
                    check($sformatf("sb16_slice%0d", c), {16'd0, sound16[16*c +: 16]},
                          {16'd0, e[12*c +: 12], 4'h0});
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        t++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    // Called on a falling edge; returns on the falling edge after T0 with t=0
    task automatic launch(input logic [15:0] dv, input logic [3:0] b3, input logic [3:0] cr);
        din   = dv;
        bits3 = b3;
`ifdef JT5205_MC_CHRST_EN
        chrst = cr;
`endif
        cen = 1'b1;
        exp_q.push_back(model_frame(dv, b3, cr));
        @(negedge clk);
        cen = 1'b0;
        t   = 0;
    endtask

    task automatic wait_done(input string nm);
        while (!done && t < 200) tick();
        check(nm, t, 20);
    endtask

    task automatic frame(input logic [15:0] dv, input logic [3:0] b3, input logic [3:0] cr);
        int bc;
        launch(dv, b3, cr);
        bc = 0;
        while (!done && t < 200) begin
            if (busy) bc++;
            tick();
        end
        check("done_latency", t, 20);
        check("busy_cycles", bc, 20);
        check("busy_low_at_done", {31'd0, busy}, 0);
        @(negedge clk);
`ifdef JT5205_MC_CHRST_EN
        chrst = '0;
`endif
    endtask

    typedef struct {
        logic        pre_rst;
        logic [15:0] din;
        logic [3:0]  bits3;
        logic        chk;
        logic [47:0] exp;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 16'h7777, 4'h0, 1'b1, {4{12'd30}}};
        vt[1] = '{1'b1, 16'h0080, 4'h0, 1'b1, {12'd2, 12'd2, 12'hFFE, 12'd2}};
        vt[2] = '{1'b1, 16'h000B, 4'h1, 1'b1, {12'd2, 12'd2, 12'd2, 12'd26}};
        vt[3] = '{1'b0, 16'h9C3A, 4'h6, 1'b0, 48'h0};
        vt[4] = '{1'b0, 16'h5F1E, 4'h9, 1'b0, 48'h0};
        vt[5] = '{1'b0, 16'h7777, 4'h0, 1'b0, 48'h0};

        repeat (2) @(negedge clk);
        check("rst_sound", {16'd0, sound[47:32]} | {16'd0, sound[31:16]} | {16'd0, sound[15:0]}, 0);
        check("rst_done_busy_ovr", {29'd0, done, busy, ovr}, 0);
        do_reset();

        // Vector table
        for (int i = 0; i < 6; i++) begin
            if (vt[i].pre_rst) do_reset();
            frame(vt[i].din, vt[i].bits3, 4'h0);
            if (vt[i].chk) begin
                for (int c = 0; c < 4; c++)
                    check($sformatf("vec%0d_slice%0d", i, c), {20'd0, sound[12*c +: 12]},
                          {20'd0, vt[i].exp[12*c +: 12]});
            end
            if (i == 0) check("ow16_slice0", {16'd0, sound16[15:0]}, 32'd480);
        end

        // Random frames from the running state
        for (int i = 0; i < 20; i++)
            frame(16'($urandom), 4'($urandom_range(0, 15)), 4'h0);

        // Per-slice update timing within a frame
        do_reset();
        launch(16'h7777, 4'h0, 4'h0);
        repeat (4) tick();
        check("slice0_before_T5", {20'd0, sound[11:0]}, 0);
        tick();
        check("slice0_at_T5", {20'd0, sound[11:0]}, 30);
        check("slice1_hold_T5", {20'd0, sound[23:12]}, 0);
        wait_done("timing_done");
        @(negedge clk);

        // Saturation at both rails
        do_reset();
        repeat (60) frame(16'h0007, 4'h0, 4'h0);
        check("sat_pos", {20'd0, sound[11:0]}, 32'h7FF);
        check("sat_pos16", {16'd0, sound16[15:0]}, 32'h7FF0);
        repeat (60) frame(16'h000F, 4'h0, 4'h0);
        check("sat_neg", {20'd0, sound[11:0]}, 32'h800);

        // Back-to-back: cen sampled on the edge where the frame ends
        do_reset();
        launch(16'h7777, 4'h0, 4'h0);
        while (t < 19) tick();
        launch(16'h3A51, 4'h2, 4'h0);
        check("b2b_done", {31'd0, done}, 1);
        check("b2b_busy", {31'd0, busy}, 1);
        tick();
        wait_done("b2b_second_done");
        check("b2b_no_ovr", {31'd0, ovr}, 0);
        @(negedge clk);

        // Overrun: strobe mid-frame is ignored but flagged
        do_reset();
        launch(16'h7777, 4'h0, 4'h0);
        while (t < 6) tick();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        check("ovr_set", {31'd0, ovr}, 1);
        check("ovr_busy", {31'd0, busy}, 1);
        wait_done("ovr_done_time");
        @(negedge clk);
        frame(16'h1111, 4'h0, 4'h0);
        check("ovr_sticky", {31'd0, ovr}, 1);

        // Reset in the middle of a frame
        launch(16'h4321, 4'h0, 4'h0);
        while (t < 8) tick();
        rst = 1'b1;
        tick();
        check("midrst_sound", {16'd0, sound[47:32] | sound[31:16] | sound[15:0]}, 0);
        check("midrst_sound16", {16'd0, sound16[63:48] | sound16[47:32] | sound16[31:16] | sound16[15:0]}, 0);
        check("midrst_flags", {29'd0, done, busy, ovr}, 0);
        exp_q.delete();
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        frame(16'h7777, 4'h0, 4'h0);
        check("after_midrst_slice3", {20'd0, sound[47:36]}, 30);

`ifdef JT5205_MC_CHRST_EN
        // Channel restart
        do_reset();
        repeat (10) frame(16'h7777, 4'h0, 4'h0);
        frame(16'h7777, 4'h0, 4'b0100);
        check("chrst_slice2", {20'd0, sound[35:24]}, 30);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
